cnn_result_checker: RTL



---
 rtl/cnn_result_checker.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cnn_result_checker.sv
// cnn_result_checker: streams multi-lane result beats, fetches the matching
// golden elements from a 1-cycle-latency BRAM port one lane at a time and
// compares them under a signed tolerance. Reports error count, first
// mismatch details and a pass flag.
`timescale 1ns/1ps
module cnn_result_checker #(
   parameter int          DATA_W    = 8,
   parameter int          LANES     = 8,
   parameter int          NUM_BEATS = 15,
   parameter int          TOL       = 0,
   parameter logic [31:0] GOLD_BASE = 32'd0,
   parameter int          ERR_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      res_valid,
   input  logic [LANES*DATA_W-1:0]   res_data,
   output logic                      res_ready,
   output logic [31:0]               BRAM_GOLD_ADDR,
   output logic                      BRAM_GOLD_EN,
   output logic [3:0]                BRAM_GOLD_WE,
   output logic [31:0]               BRAM_GOLD_DIN,
   input  logic [31:0]               BRAM_GOLD_DOUT,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [ERR_W-1:0]          err_cnt,
   output logic                      first_valid,
   output logic [15:0]               first_beat,
   output logic [7:0]                first_lane,
   output logic [DATA_W-1:0]         first_got,
   output logic [DATA_W-1:0]         first_exp
);

   localparam int KW = $clog2(LANES + 1);
   localparam int BW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [KW-1:0]     K_LAST = KW'(LANES - 1);   // last lane that still issues a read
   localparam logic [KW-1:0]     K_END  = KW'(LANES);       // final compare cycle of a beat
   localparam logic [BW-1:0]     B_LAST = BW'(NUM_BEATS - 1);
   localparam logic [DATA_W:0]   TOL_V  = (DATA_W + 1)'(TOL);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_BEAT, S_READ, S_DONE} state_t;

   state_t state_q, state_nx;

   logic [LANES-1:0][DATA_W-1:0] lat;      // latched beat, shifted down one lane per compare
   logic [KW-1:0]                k;
   logic [BW-1:0]                b;
   logic [31:0]                  elem;     // running golden element index
   logic                         hs;
   logic                         last_beat;

   logic [DATA_W-1:0]            got, expv;
   logic [DATA_W:0]              diff, mag;
   logic                         mismatch;

   assign BRAM_GOLD_WE  = '0;
   assign BRAM_GOLD_DIN = '0;

   // res_ready is a registered copy of "in WAIT_BEAT", so the handshake never
   // depends combinationally on res_valid.
   assign hs        = res_valid & res_ready;
   assign last_beat = (b == B_LAST);

   // Signed compare of the oldest latched lane against the BRAM read data.
   always_comb begin
      got      = lat[0];
      expv     = BRAM_GOLD_DOUT[DATA_W-1:0];
      diff     = {got[DATA_W-1], got} - {expv[DATA_W-1], expv};
      mag      = diff[DATA_W] ? (~diff + (DATA_W + 1)'(1)) : diff;
      mismatch = (mag > TOL_V);
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_nx = S_WAIT_BEAT;
         S_WAIT_BEAT:    if (hs)    state_nx = S_READ;
         S_READ:         if (k == K_END) state_nx = last_beat ? S_DONE : S_WAIT_BEAT;
         default:        state_nx = S_IDLE;
      endcase
   end

   // Datapath: counters, BRAM requests, compare bookkeeping and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_ready      <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_cnt        <= '0;
         first_valid    <= 1'b0;
         first_beat     <= '0;
         first_lane     <= '0;
         first_got      <= '0;
         first_exp      <= '0;
         BRAM_GOLD_EN   <= 1'b0;
         BRAM_GOLD_ADDR <= '0;
         lat            <= '0;
         k              <= '0;
         b              <= '0;
         elem           <= '0;
      end else begin
         res_ready    <= (state_nx == S_WAIT_BEAT);
         busy         <= (state_nx == S_WAIT_BEAT) || (state_nx == S_READ);
         BRAM_GOLD_EN <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  err_cnt     <= '0;
                  first_valid <= 1'b0;
                  first_beat  <= '0;
                  first_lane  <= '0;
                  first_got   <= '0;
                  first_exp   <= '0;
                  b           <= '0;
                  elem        <= '0;
               end
            end
            S_WAIT_BEAT: begin
               if (hs) begin
                  // Issue lane 0's read together with the beat capture so the
                  // first READ cycle already has its address on the port.
                  lat            <= res_data;
                  k              <= '0;
                  BRAM_GOLD_EN   <= 1'b1;
                  BRAM_GOLD_ADDR <= GOLD_BASE + {elem[29:0], 2'b00};
                  elem           <= elem + 32'd1;
               end
            end
            S_READ: begin
               if (k < K_LAST) begin
                  BRAM_GOLD_EN   <= 1'b1;
                  BRAM_GOLD_ADDR <= GOLD_BASE + {elem[29:0], 2'b00};
                  elem           <= elem + 32'd1;
               end
               if (k != '0) begin
                  lat <= lat >> DATA_W;
                  if (mismatch) begin
                     if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                     if (!first_valid) begin
                        first_valid <= 1'b1;
                        first_beat  <= 16'(b);
                        first_lane  <= 8'(k - KW'(1));
                        first_got   <= got;
                        first_exp   <= expv;
                     end
                  end
               end
               k <= k + KW'(1);
               if (k == K_END) begin
                  b <= b + BW'(1);
                  if (last_beat) begin
                     done <= 1'b1;
                     pass <= (err_cnt == '0) && !mismatch;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
